// File: rtl/axi_burst_master_pkg.sv
// ---------------------------------------------------------------------------
// axi_burst_master_pkg
// Shared AXI constants and types for the burst master:
//   - burst type / size / response encodings
//   - FSM state enum for the master
//   - request descriptor struct (write, addr, len, strb) at default widths
//   - resp_worst(): merges two AXI responses, keeping the more severe one
// ---------------------------------------------------------------------------
package axi_burst_master_pkg;

  localparam int AXI_ID_BITS   = 4;
  localparam int AXI_ADDR_BITS = 32;
  localparam int AXI_DATA_BITS = 32;
  localparam int AXI_LEN_BITS  = 4;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_4B     = 3'b010;
  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RADDR,
    ST_RDATA,
    ST_WADDR,
    ST_WDATA,
    ST_WRESP
  } mst_state_t;

  typedef struct packed {
    logic                         write;
    logic [AXI_ADDR_BITS-1:0]     addr;
    logic [AXI_LEN_BITS-1:0]      len;
    logic [AXI_DATA_BITS/8-1:0]   strb;
  } axi_req_t;

  // AXI response severity is ordered numerically (OKAY < SLVERR < DECERR).
  function automatic logic [1:0] resp_worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_burst_master_if.sv
// ---------------------------------------------------------------------------
// axi_burst_master_if
// AXI4 read/write channel bundle between an initiator and a slave.
//   AR: ARID, ARAddr, ARLen, ARSize, ARBurst, ARValid / ARReady
//   R : RID, RData, RResp, RLast, RValid / RReady
//   AW: AWID, AWAddr, AWLen, AWSize, AWBurst, AWValid / AWReady
//   W : WData, WStrb, WLast, WValid / WReady
//   B : BID, BResp, BValid / BReady
// modport master drives the request side, modport slave the response side.
// ---------------------------------------------------------------------------
interface axi_burst_master_if #(
  parameter int ID_BITS   = 4,
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32,
  parameter int LEN_BITS  = 4
);

  logic [ID_BITS-1:0]     ARID;
  logic [ADDR_BITS-1:0]   ARAddr;
  logic [LEN_BITS-1:0]    ARLen;
  logic [2:0]             ARSize;
  logic [1:0]             ARBurst;
  logic                   ARValid;
  logic                   ARReady;

  logic [ID_BITS-1:0]     RID;
  logic [DATA_BITS-1:0]   RData;
  logic [1:0]             RResp;
  logic                   RLast;
  logic                   RValid;
  logic                   RReady;

  logic [ID_BITS-1:0]     AWID;
  logic [ADDR_BITS-1:0]   AWAddr;
  logic [LEN_BITS-1:0]    AWLen;
  logic [2:0]             AWSize;
  logic [1:0]             AWBurst;
  logic                   AWValid;
  logic                   AWReady;

  logic [DATA_BITS-1:0]   WData;
  logic [DATA_BITS/8-1:0] WStrb;
  logic                   WLast;
  logic                   WValid;
  logic                   WReady;

  logic [ID_BITS-1:0]     BID;
  logic [1:0]             BResp;
  logic                   BValid;
  logic                   BReady;

  modport master (
    output ARID, ARAddr, ARLen, ARSize, ARBurst, ARValid,
    input  ARReady,
    input  RID, RData, RResp, RLast, RValid,
    output RReady,
    output AWID, AWAddr, AWLen, AWSize, AWBurst, AWValid,
    input  AWReady,
    output WData, WStrb, WLast, WValid,
    input  WReady,
    input  BID, BResp, BValid,
    output BReady
  );

  modport slave (
    input  ARID, ARAddr, ARLen, ARSize, ARBurst, ARValid,
    output ARReady,
    output RID, RData, RResp, RLast, RValid,
    input  RReady,
    input  AWID, AWAddr, AWLen, AWSize, AWBurst, AWValid,
    output AWReady,
    input  WData, WStrb, WLast, WValid,
    output WReady,
    output BID, BResp, BValid,
    input  BReady
  );

endinterface

// File: rtl/axi_burst_master.sv
// ---------------------------------------------------------------------------
// axi_burst_master
// Single-outstanding AXI4 initiator. Turns one request (read or write burst)
// plus user data streams into AXI bursts; write path is ordered AW -> W -> B.
// Ports:
//   clk, rst (synchronous, active-low)
//   req_valid/req_ready, req_write, req_addr, req_len (beats-1), req_strb
//   usr_wdata/usr_wvalid/usr_wready : write beat stream (pass-through to W)
//   usr_rdata/usr_rvalid/usr_rready : read beat stream (pass-through from R)
//   done (1-cycle pulse), done_resp (final merged AXI response)
//   m : AXI master modport
// ---------------------------------------------------------------------------
module axi_burst_master
  import axi_burst_master_pkg::*;
#(
  parameter int ID_BITS   = 4,
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32,
  parameter int LEN_BITS  = 4,
  parameter int MST_ID    = 0
) (
  input  logic                   clk,
  input  logic                   rst,

  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [ADDR_BITS-1:0]   req_addr,
  input  logic [LEN_BITS-1:0]    req_len,
  input  logic [DATA_BITS/8-1:0] req_strb,

  input  logic [DATA_BITS-1:0]   usr_wdata,
  input  logic                   usr_wvalid,
  output logic                   usr_wready,

  output logic [DATA_BITS-1:0]   usr_rdata,
  output logic                   usr_rvalid,
  input  logic                   usr_rready,

  output logic                   done,
  output logic [1:0]             done_resp,

  axi_burst_master_if.master     m
);

  mst_state_t             state_reg, state_next;
  logic [LEN_BITS-1:0]    cnt_reg;
  logic [ADDR_BITS-1:0]   addr_reg;
  logic [LEN_BITS-1:0]    len_reg;
  logic [DATA_BITS/8-1:0] strb_reg;
  logic [1:0]             worst_reg;
  logic                   mismatch_reg;
  logic                   done_reg;
  logic [1:0]             done_resp_reg;

  logic accept;
  logic r_beat;
  logic w_beat;
  logic at_last;
  logic r_bad;

  // IDs are not checked: only one ID is ever outstanding.
  logic unused_ids;
  assign unused_ids = ^{m.RID, m.BID};

  assign at_last = (cnt_reg == len_reg);
  assign accept  = (state_reg == ST_IDLE) && !done_reg && req_valid;
  assign r_beat  = (state_reg == ST_RDATA) && m.RValid && usr_rready;
  assign w_beat  = (state_reg == ST_WDATA) && usr_wvalid && m.WReady;
  // Slave's RLast must coincide exactly with the expected final beat.
  assign r_bad   = (m.RLast != at_last);

  // Address channels are decoded straight from the state register, so the
  // valids are glitch-free and address/len come from latched registers.
  assign m.ARID    = ID_BITS'(MST_ID);
  assign m.ARAddr  = addr_reg;
  assign m.ARLen   = len_reg;
  assign m.ARSize  = SIZE_4B;
  assign m.ARBurst = BURST_INCR;
  assign m.ARValid = (state_reg == ST_RADDR);

  assign m.AWID    = ID_BITS'(MST_ID);
  assign m.AWAddr  = addr_reg;
  assign m.AWLen   = len_reg;
  assign m.AWSize  = SIZE_4B;
  assign m.AWBurst = BURST_INCR;
  assign m.AWValid = (state_reg == ST_WADDR);

  assign m.WData   = usr_wdata;
  assign m.WStrb   = strb_reg;
  assign usr_rdata = m.RData;

  assign done      = done_reg;
  assign done_resp = done_resp_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    m.RReady   = 1'b0;
    m.WValid   = 1'b0;
    m.WLast    = 1'b0;
    m.BReady   = 1'b0;
    usr_wready = 1'b0;
    usr_rvalid = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // Held off during the done cycle so back-to-back requests are spaced.
        req_ready = !done_reg;
        if (accept) begin
          state_next = req_write ? ST_WADDR : ST_RADDR;
        end
      end
      ST_RADDR: begin
        if (m.ARReady) state_next = ST_RDATA;
      end
      ST_RDATA: begin
        m.RReady   = usr_rready;
        usr_rvalid = m.RValid;
        // Only RLast ends the burst, even after a length mismatch.
        if (r_beat && m.RLast) state_next = ST_IDLE;
      end
      ST_WADDR: begin
        if (m.AWReady) state_next = ST_WDATA;
      end
      ST_WDATA: begin
        m.WValid   = usr_wvalid;
        usr_wready = m.WReady;
        m.WLast    = at_last;
        if (w_beat && at_last) state_next = ST_WRESP;
      end
      ST_WRESP: begin
        m.BReady = 1'b1;
        if (m.BValid) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_reg       <= '0;
      addr_reg      <= '0;
      len_reg       <= '0;
      strb_reg      <= '0;
      worst_reg     <= RESP_OKAY;
      mismatch_reg  <= 1'b0;
      done_reg      <= 1'b0;
      done_resp_reg <= RESP_OKAY;
    end else begin
      done_reg <= 1'b0;

      if (accept) begin
        addr_reg      <= req_addr;
        len_reg       <= req_len;
        strb_reg      <= req_strb;
        cnt_reg       <= '0;
        worst_reg     <= RESP_OKAY;
        mismatch_reg  <= 1'b0;
        done_resp_reg <= RESP_OKAY;
      end

      if (r_beat) begin
        // Stop counting on the closing beat so len=max never wraps.
        if (!m.RLast) cnt_reg <= cnt_reg + LEN_BITS'(1);
        worst_reg    <= resp_worst(worst_reg, m.RResp);
        mismatch_reg <= mismatch_reg | r_bad;
        if (m.RLast) begin
          done_reg      <= 1'b1;
          done_resp_reg <= (mismatch_reg | r_bad) ? RESP_SLVERR
                                                  : resp_worst(worst_reg, m.RResp);
        end
      end

      if (w_beat && !at_last) begin
        cnt_reg <= cnt_reg + LEN_BITS'(1);
      end

      if ((state_reg == ST_WRESP) && m.BValid) begin
        done_reg      <= 1'b1;
        done_resp_reg <= m.BResp;
      end
    end
  end

endmodule
